// File: rtl/uart_rx_fsm.sv
// UART receive controller: start-bit detection, per-bit edge counting and sampler enable,
// LSB-first deserialization, optional parity and stop-bit checks with one-cycle result strobes.
module uart_rx_fsm #(
   parameter int Prescale_Width = 6,
   parameter int DATA_WIDTH     = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [Prescale_Width-1:0] Prescale,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic                      sampled_bit,
   output logic                      dat_samp_en,
   output logic [Prescale_Width-1:0] edge_cnt,
   output logic [DATA_WIDTH-1:0]     P_DATA,
   output logic                      data_valid,
   output logic                      parity_error,
   output logic                      stop_error
);

   // state  | meaning
   // IDLE   | line idle; waits for RX_IN low with a supported Prescale
   // START  | timing the start bit; a 1 at bit end is a false start
   // DATA   | shifting in DATA_WIDTH bits, LSB first
   // PARITY | comparing the parity bit against the received byte
   // STOP   | checking the stop bit; result strobes register for the next cycle
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [3:0]                LAST_BIT = 4'(DATA_WIDTH - 1);
   localparam logic [Prescale_Width-1:0] ONE      = Prescale_Width'(1);

   logic [2:0]                state_q, state_d;
   logic [Prescale_Width-1:0] edge_q, edge_d;
   logic [Prescale_Width-1:0] pre_q, pre_d;
   logic [3:0]                bit_q, bit_d;
   logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0]     pdata_q, pdata_d;
   logic                      par_en_q, par_en_d;
   logic                      par_typ_q, par_typ_d;
   logic                      par_err_q, par_err_d;
   logic                      dv_q, dv_d;
   logic                      pe_q, pe_d;
   logic                      se_q, se_d;

   logic pre_ok;
   logic bit_end;
   logic exp_par;
   logic stp_err;

   always_comb begin
      pre_ok  = (Prescale == Prescale_Width'(4))  || (Prescale == Prescale_Width'(8)) ||
                (Prescale == Prescale_Width'(16)) || (Prescale == Prescale_Width'(32));
      bit_end = (edge_q == (pre_q - ONE));
      exp_par = par_typ_q ? ~^shreg_q : ^shreg_q;
      stp_err = ~sampled_bit;
   end

   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      pdata_d   = pdata_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      par_err_d = par_err_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;

      if (state_q == S_IDLE) begin
         edge_d = '0;
      end else if (bit_end) begin
         edge_d = '0;
      end else begin
         edge_d = edge_q + ONE;
      end

      case (state_q)
         S_IDLE: begin
            bit_d     = '0;
            par_err_d = 1'b0;
            if (!RX_IN && pre_ok) begin
               state_d   = S_START;
               pre_d     = Prescale;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = sampled_bit ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
               bit_d   = bit_q + 4'd1;
               if (bit_q == LAST_BIT) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               if (sampled_bit != exp_par) begin
                  par_err_d = 1'b1;
               end
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               // P_DATA only moves on a clean frame so software always sees the last good byte
               dv_d = ~par_err_q & ~stp_err;
               pe_d = par_err_q;
               se_d = stp_err;
               if (~par_err_q & ~stp_err) begin
                  pdata_d = shreg_q;
               end
               state_d   = S_IDLE;
               bit_d     = '0;
               par_err_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         edge_q    <= '0;
         pre_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         pdata_q   <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         par_err_q <= 1'b0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         edge_q    <= edge_d;
         pre_q     <= pre_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         pdata_q   <= pdata_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         par_err_q <= par_err_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
      end
   end

   // The sampler clears its decision when disabled, so enable spans every non-idle cycle
   assign dat_samp_en  = (state_q != S_IDLE);
   assign edge_cnt     = edge_q;
   assign P_DATA       = pdata_q;
   assign data_valid   = dv_q;
   assign parity_error = pe_q;
   assign stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: behavioural sampler, frame-level reference model of expected
// strobe cycle and contents, directed scenarios plus randomized frames.
module tb_uart_rx_fsm;

   typedef struct packed {
      logic [31:0] c;
      logic        dv;
      logic        pe;
      logic        se;
      logic [7:0]  pd;
   } ev_t;

   logic       CLK      = 1'b0;
   logic       RST      = 1'b0;
   logic       RX_IN    = 1'b1;
   logic [5:0] Prescale = 6'd8;
   logic       PAR_EN   = 1'b0;
   logic       PAR_TYP  = 1'b0;
   logic       sampled_bit;
   logic       dat_samp_en;
   logic [5:0] edge_cnt;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       parity_error;
   logic       stop_error;

   int         vectors     = 0;
   int         miscompares = 0;
   int         cyc         = 0;
   int         free_at     = 0;
   logic [7:0] pdata_m     = 8'h00;
   logic [5:0] samp_pre;
   ev_t        act_q[$];
   ev_t        exp_q[$];
   ev_t        mon_ev;

   uart_rx_fsm #(.Prescale_Width(6), .DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .dat_samp_en(dat_samp_en),
      .edge_cnt(edge_cnt), .P_DATA(P_DATA), .data_valid(data_valid),
      .parity_error(parity_error), .stop_error(stop_error)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Data-sampling block: single sample at mid-bit (edge 1 for Prescale=4), cleared when disabled
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sampled_bit <= 1'b0;
         samp_pre    <= 6'd8;
      end else if (!dat_samp_en) begin
         sampled_bit <= 1'b0;
         samp_pre    <= Prescale;
      end else if (edge_cnt == ((samp_pre == 6'd4) ? 6'd1 : (samp_pre >> 1))) begin
         sampled_bit <= RX_IN;
      end
   end

   always @(negedge CLK) begin
      if (RST === 1'b1 && (data_valid || parity_error || stop_error)) begin
         mon_ev.c  = 32'(cyc);
         mon_ev.dv = data_valid;
         mon_ev.pe = parity_error;
         mon_ev.se = stop_error;
         mon_ev.pd = P_DATA;
         act_q.push_back(mon_ev);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at 2ms, required finish");
      $fatal(1);
   end

   task automatic drive_cycle(input logic v);
      @(posedge CLK);
      #1 RX_IN = v;
   endtask

   task automatic settle();
      int n;
      n = (exp_q.size() > 0) ? (int'(exp_q[$].c) - cyc + 4) : 4;
      if (n < 4) n = 4;
      repeat (n) drive_cycle(1'b1);
   endtask

   // Drives one frame and appends the expected frame result to exp_q
   task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                             input bit pbit, input bit sbit, input int gap, input bit scramble);
      logic b[$];
      int   n, t0, dcy;
      bit   pe, se;
      ev_t  e;
      repeat (gap) drive_cycle(1'b1);
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(d[i]);
      if (pen) b.push_back(pbit);
      b.push_back(sbit);
      n = b.size();
      @(posedge CLK);
      #1;
      Prescale = 6'(p);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      RX_IN    = 1'b0;
      t0       = cyc;
      for (int i = 1; i < p * n; i++) begin
         @(posedge CLK);
         #1 RX_IN = b[i / p];
         if (scramble && i >= 3 && i < p * n - 2) begin
            Prescale = 6'($urandom_range(0, 63));
            PAR_EN   = 1'($urandom_range(0, 1));
            PAR_TYP  = 1'($urandom_range(0, 1));
         end
      end
      dcy     = (t0 >= free_at) ? t0 : free_at;
      free_at = dcy + p * n + 1;
      pe      = pen && (pbit != (ptyp ? ~^d : ^d));
      se      = !sbit;
      if (!pe && !se) pdata_m = d;
      e.c  = 32'(dcy + p * n + 1);
      e.dv = !pe && !se;
      e.pe = pe;
      e.se = se;
      e.pd = pdata_m;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      RST   = 1'b0;
      RX_IN = 1'b1;
      repeat (3) @(negedge CLK);
      vectors++;
      if (dat_samp_en !== 1'b0) begin
         miscompares++; $display("FAIL reset_en: got %b, required 0", dat_samp_en);
      end
      vectors++;
      if (edge_cnt !== 6'd0) begin
         miscompares++; $display("FAIL reset_edge: got %0d, required 0", edge_cnt);
      end
      vectors++;
      if (P_DATA !== 8'h00) begin
         miscompares++; $display("FAIL reset_pdata: got %h, required 00", P_DATA);
      end
      vectors++;
      if ({data_valid, parity_error, stop_error} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_strobes: got %b%b%b, required 000", data_valid, parity_error, stop_error);
      end
      RST = 1'b1;
      repeat (4) drive_cycle(1'b1);
      @(negedge CLK);
      vectors++;
      if ({dat_samp_en, edge_cnt, P_DATA, data_valid, parity_error, stop_error} !== 18'd0) begin
         miscompares++;
         $display("FAIL reset_idle: got en=%b edge=%0d pd=%h, required all 0", dat_samp_en, edge_cnt, P_DATA);
      end
   endtask

   task automatic test_basic();
      ev_t a, e;
      send_frame(8, 0, 0, 8'hA5, 0, 1, 2, 0);
      settle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (act_q.size() == 0) begin
            miscompares++;
            $display("FAIL basic_frame: no strobe, required cyc=%0d dv=%b pe=%b se=%b pd=%h", e.c, e.dv, e.pe, e.se, e.pd);
         end else begin
            a = act_q.pop_front();
            if (a !== e) begin
               miscompares++;
               $display("FAIL basic_frame: got cyc=%0d dv=%b pe=%b se=%b pd=%h, required cyc=%0d dv=%b pe=%b se=%b pd=%h",
                        a.c, a.dv, a.pe, a.se, a.pd, e.c, e.dv, e.pe, e.se, e.pd);
            end
         end
      end
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL basic_extra: got %0d extra strobes, required 0", act_q.size()); act_q.delete();
      end
   endtask

   task automatic test_parity();
      ev_t a, e;
      send_frame(16, 1, 0, 8'h3C, 0, 1, 2, 0);
      send_frame(16, 1, 0, 8'h3D, 0, 1, 2, 0);
      settle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (act_q.size() == 0) begin
            miscompares++;
            $display("FAIL parity_frame: no strobe, required cyc=%0d dv=%b pe=%b se=%b pd=%h", e.c, e.dv, e.pe, e.se, e.pd);
         end else begin
            a = act_q.pop_front();
            if (a !== e) begin
               miscompares++;
               $display("FAIL parity_frame: got cyc=%0d dv=%b pe=%b se=%b pd=%h, required cyc=%0d dv=%b pe=%b se=%b pd=%h",
                        a.c, a.dv, a.pe, a.se, a.pd, e.c, e.dv, e.pe, e.se, e.pd);
            end
         end
      end
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL parity_extra: got %0d extra strobes, required 0", act_q.size()); act_q.delete();
      end
   endtask

   task automatic test_stop_error();
      ev_t a, e;
      send_frame(32, 1, 1, 8'h01, 0, 0, 2, 0);
      settle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (act_q.size() == 0) begin
            miscompares++;
            $display("FAIL stop_frame: no strobe, required cyc=%0d dv=%b pe=%b se=%b pd=%h", e.c, e.dv, e.pe, e.se, e.pd);
         end else begin
            a = act_q.pop_front();
            if (a !== e) begin
               miscompares++;
               $display("FAIL stop_frame: got cyc=%0d dv=%b pe=%b se=%b pd=%h, required cyc=%0d dv=%b pe=%b se=%b pd=%h",
                        a.c, a.dv, a.pe, a.se, a.pd, e.c, e.dv, e.pe, e.se, e.pd);
            end
         end
      end
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL stop_extra: got %0d extra strobes, required 0", act_q.size()); act_q.delete();
      end
   endtask

   task automatic test_false_start();
      int en_cycles = 0;
      repeat (3) drive_cycle(1'b1);
      @(posedge CLK);
      #1;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      @(negedge CLK);
      if (dat_samp_en) en_cycles++;
      drive_cycle(1'b0);
      @(negedge CLK);
      if (dat_samp_en) en_cycles++;
      repeat (20) begin
         drive_cycle(1'b1);
         @(negedge CLK);
         if (dat_samp_en) en_cycles++;
      end
      vectors++;
      if (en_cycles != 8) begin
         miscompares++; $display("FAIL false_start_en: got %0d enable cycles, required 8", en_cycles);
      end
      vectors++;
      if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
         miscompares++; $display("FAIL false_start_idle: got en=%b edge=%0d, required 0 0", dat_samp_en, edge_cnt);
      end
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL false_start_strobe: got %0d strobes, required 0", act_q.size()); act_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      ev_t a, e;
      send_frame(4, 0, 0, 8'h00, 0, 1, 2, 0);
      send_frame(4, 0, 0, 8'hFF, 0, 1, 0, 0);
      settle();
      vectors++;
      if (act_q.size() < 2) begin
         miscompares++; $display("FAIL b2b_spacing: got %0d strobes, required 2 spaced 41", act_q.size());
      end else if (int'(act_q[1].c) - int'(act_q[0].c) != 41) begin
         miscompares++;
         $display("FAIL b2b_spacing: got %0d cycles apart, required 41", int'(act_q[1].c) - int'(act_q[0].c));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (act_q.size() == 0) begin
            miscompares++;
            $display("FAIL b2b_frame: no strobe, required cyc=%0d dv=%b pe=%b se=%b pd=%h", e.c, e.dv, e.pe, e.se, e.pd);
         end else begin
            a = act_q.pop_front();
            if (a !== e) begin
               miscompares++;
               $display("FAIL b2b_frame: got cyc=%0d dv=%b pe=%b se=%b pd=%h, required cyc=%0d dv=%b pe=%b se=%b pd=%h",
                        a.c, a.dv, a.pe, a.se, a.pd, e.c, e.dv, e.pe, e.se, e.pd);
            end
         end
      end
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL b2b_extra: got %0d extra strobes, required 0", act_q.size()); act_q.delete();
      end
   endtask

   task automatic test_reset_mid_frame();
      ev_t        a, e;
      logic [7:0] d;
      logic       b[$];
      d = 8'($urandom);
      b.push_back(1'b0);
      for (int i = 0; i < 4; i++) b.push_back(d[i]);
      repeat (3) drive_cycle(1'b1);
      @(posedge CLK);
      #1;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      for (int i = 1; i < 36; i++) drive_cycle(b[i / 8]);
      @(negedge CLK);
      RST   = 1'b0;
      RX_IN = 1'b1;
      #1;
      vectors++;
      if ({dat_samp_en, edge_cnt, P_DATA, data_valid, parity_error, stop_error} !== 18'd0) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got en=%b edge=%0d pd=%h dv=%b pe=%b se=%b, required all 0",
                  dat_samp_en, edge_cnt, P_DATA, data_valid, parity_error, stop_error);
      end
      pdata_m = 8'h00;
      free_at = 0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (20) drive_cycle(1'b1);
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL rst_mid_strobe: got %0d strobes, required 0", act_q.size()); act_q.delete();
      end
      send_frame(8, 0, 0, 8'h5A, 0, 1, 1, 0);
      settle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (act_q.size() == 0) begin
            miscompares++;
            $display("FAIL rst_mid_frame: no strobe, required cyc=%0d dv=%b pe=%b se=%b pd=%h", e.c, e.dv, e.pe, e.se, e.pd);
         end else begin
            a = act_q.pop_front();
            if (a !== e) begin
               miscompares++;
               $display("FAIL rst_mid_frame: got cyc=%0d dv=%b pe=%b se=%b pd=%h, required cyc=%0d dv=%b pe=%b se=%b pd=%h",
                        a.c, a.dv, a.pe, a.se, a.pd, e.c, e.dv, e.pe, e.se, e.pd);
            end
         end
      end
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL rst_mid_extra: got %0d extra strobes, required 0", act_q.size()); act_q.delete();
      end
   endtask

   task automatic test_bad_prescale();
      int bad = 0;
      @(posedge CLK);
      #1;
      Prescale = 6'd6;
      RX_IN    = 1'b0;
      repeat (40) begin
         @(negedge CLK);
         if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) bad++;
         drive_cycle(1'b0);
      end
      repeat (5) drive_cycle(1'b1);
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL bad_prescale_idle: got %0d non-idle cycles, required 0", bad);
      end
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL bad_prescale_strobe: got %0d strobes, required 0", act_q.size()); act_q.delete();
      end
   endtask

   task automatic test_random();
      ev_t a, e;
      for (int k = 0; k < 30; k++) begin
         send_frame(4 << $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
                    int'($urandom_range(1, 3)), 1'b1);
      end
      settle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (act_q.size() == 0) begin
            miscompares++;
            $display("FAIL random_frame: no strobe, required cyc=%0d dv=%b pe=%b se=%b pd=%h", e.c, e.dv, e.pe, e.se, e.pd);
         end else begin
            a = act_q.pop_front();
            if (a !== e) begin
               miscompares++;
               $display("FAIL random_frame: got cyc=%0d dv=%b pe=%b se=%b pd=%h, required cyc=%0d dv=%b pe=%b se=%b pd=%h",
                        a.c, a.dv, a.pe, a.se, a.pd, e.c, e.dv, e.pe, e.se, e.pd);
            end
         end
      end
      vectors++;
      if (act_q.size() != 0) begin
         miscompares++; $display("FAIL random_extra: got %0d extra strobes, required 0", act_q.size()); act_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_stop_error();
      test_false_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_bad_prescale();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
